// File: rtl/cq_viola_sysid_checker.sv
// cq_viola_sysid_checker: Avalon-MM read-back of the sysid ID and timestamp words with a latched verdict.
// Rev 1.0
`default_nettype none

module cq_viola_sysid_checker #(
  parameter logic [31:0] EXPECT_ID      = 32'hA0130917,
  parameter logic [31:0] EXPECT_TS      = 32'h52673D51,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        fault,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic               id_ok_q, id_ok_d;
  logic               ts_ok_q, ts_ok_d;
  logic               fault_q, fault_d;
  logic [31:0]        id_value_q, id_value_d;
  logic [31:0]        ts_value_q, ts_value_d;
  logic               rd_q, rd_d;
  logic               addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               auto_q, auto_d;
  logic               go;
  logic               id_eq;
  logic               ts_eq;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    match_d    = match_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    fault_d    = fault_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    auto_d     = 1'b0;
    go         = start | auto_q;
    id_eq      = (avm_readdata == EXPECT_ID);
    ts_eq      = (avm_readdata == EXPECT_TS);

    case (state_q)
      ST_RD_ID, ST_RD_TS: begin
        if (!avm_waitrequest) begin
          cnt_d = '0;
          if (state_q == ST_RD_ID) begin
            // read stays asserted so the timestamp read follows without a gap
            id_value_d = avm_readdata;
            id_ok_d    = id_eq;
            addr_d     = 1'b1;
            state_d    = ST_RD_TS;
          end else begin
            ts_value_d = avm_readdata;
            ts_ok_d    = ts_eq;
            match_d    = id_ok_q & ts_eq;
            done_d     = 1'b1;
            rd_d       = 1'b0;
            addr_d     = 1'b0;
            busy_d     = 1'b0;
            state_d    = ST_DONE;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          fault_d = 1'b1;
          match_d = 1'b0;
          rd_d    = 1'b0;
          addr_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (go) begin
          match_d = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          fault_d = 1'b0;
          cnt_d   = '0;
          rd_d    = 1'b1;
          addr_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_RD_ID;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      fault_q    <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      rd_q       <= 1'b0;
      addr_q     <= 1'b0;
      cnt_q      <= '0;
      auto_q     <= AUTO_START;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      fault_q    <= fault_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign match       = match_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign fault       = fault_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign avm_read    = rd_q;
  assign avm_address = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_cq_viola_sysid_checker.sv
// tb_cq_viola_sysid_checker: randomized self-checking bench with a transaction-level reference model.
// Rev 1.0
`default_nettype none

module tb_cq_viola_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hA0130917;
  localparam logic [31:0] EXP_TS = 32'h52673D51;
  localparam int          TMO    = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, match, id_ok, ts_ok, fault;
  logic [31:0] id_value, ts_value, avm_readdata;
  logic        avm_address, avm_read, avm_waitrequest;

  logic        reset_b, start_b, wr_b;
  logic        busy_b, done_b, match_b, id_ok_b, ts_ok_b, fault_b;
  logic [31:0] id_value_b, ts_value_b, readdata_b;
  logic        addr_b, read_b;

  logic [31:0] id_word, ts_word;
  int          st_id, st_ts, scnt;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_id_val, m_ts_val;

  always #5 clk = ~clk;

  // Slave model: stall each read for a programmed number of cycles.
  assign avm_readdata    = avm_address ? ts_word : id_word;
  assign avm_waitrequest = avm_read && (scnt < (avm_address ? st_ts : st_id));
  always @(posedge clk) begin
    if (!avm_read || !avm_waitrequest) scnt <= 0;
    else scnt <= scnt + 1;
  end

  assign readdata_b = addr_b ? EXP_TS : EXP_ID;

  cq_viola_sysid_checker #(.TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)) dut (
    .clock(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .match(match), .id_ok(id_ok), .ts_ok(ts_ok), .fault(fault),
    .id_value(id_value), .ts_value(ts_value), .avm_address(avm_address),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  cq_viola_sysid_checker #(.AUTO_START(1'b0)) dut_b (
    .clock(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
    .match(match_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .fault(fault_b),
    .id_value(id_value_b), .ts_value(ts_value_b), .avm_address(addr_b),
    .avm_read(read_b), .avm_waitrequest(wr_b), .avm_readdata(readdata_b)
  );

  // Run one check on the main DUT and report what was observed.
  task automatic transact(input logic [31:0] idw, input logic [31:0] tsw,
                          input int sid, input int sts, input bit pulse_mid,
                          output int lat, output bit saw_done, output bit saw_fault,
                          output int acc_n, output int acc_seq, output bit unstable,
                          output int extra_done, output bit end_busy);
    bit   prev_stall;
    logic prev_addr;
    id_word = idw; ts_word = tsw; st_id = sid; st_ts = sts;
    lat = 0; saw_done = 0; saw_fault = 0; acc_n = 0; acc_seq = 0;
    unstable = 0; extra_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 60 && !(saw_done || saw_fault); c++) begin
      if (avm_read && !avm_waitrequest) begin
        acc_seq = acc_seq * 2 + int'(avm_address);
        acc_n++;
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      @(posedge clk); #1;
      start = pulse_mid && (c == 1);
      if (prev_stall && !fault && (!avm_read || avm_address !== prev_addr)) unstable = 1;
      if (done)  begin saw_done  = 1; lat = c; end
      if (fault) begin saw_fault = 1; lat = c; end
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    end_busy = busy;
  endtask

  // Reference: outcome of one check from stall counts and data words.
  task automatic model(input logic [31:0] idw, input logic [31:0] tsw, input int sid, input int sts,
                       output bit e_done, output bit e_fault, output int e_lat, output int e_accn,
                       output int e_seq, output bit e_idok, output bit e_tsok, output bit e_match);
    bit f_id, f_ts;
    f_id = (sid >= TMO);
    f_ts = !f_id && (sts >= TMO);
    e_fault = f_id || f_ts;
    e_done  = !e_fault;
    e_idok  = !f_id && (idw == EXP_ID);
    e_tsok  = e_done && (tsw == EXP_TS);
    e_match = e_idok && e_tsok;
    if (f_id)      begin e_lat = 1 + TMO;       e_accn = 0; e_seq = 0; end
    else if (f_ts) begin e_lat = 2 + sid + TMO; e_accn = 1; e_seq = 0; end
    else           begin e_lat = 3 + sid + sts; e_accn = 2; e_seq = 1; end
    if (!f_id)  m_id_val = idw;
    if (e_done) m_ts_val = tsw;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, match, id_ok, ts_ok, fault, avm_read, avm_address} !== 8'h00)
      $display("FAIL reset_flags: got %b want 00000000", {busy, done, match, id_ok, ts_ok, fault, avm_read, avm_address});
    else n_pass++;
    n_checks++;
    if (id_value !== 32'h0 || ts_value !== 32'h0)
      $display("FAIL reset_values: got %h/%h want 0/0", id_value, ts_value);
    else n_pass++;
  endtask

  task automatic test_auto_start();
    int lat, acc_n, acc_seq;
    lat = 0; acc_n = 0; acc_seq = 0;
    id_word = EXP_ID; ts_word = EXP_TS; st_id = 0; st_ts = 0;
    reset = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (avm_read && !avm_waitrequest) begin
        acc_seq = acc_seq * 2 + int'(avm_address);
        acc_n++;
      end
      @(posedge clk); #1;
      if (done) lat = c;
    end
    n_checks++;
    if (lat !== 3) $display("FAIL auto_latency: got %0d want 3", lat); else n_pass++;
    n_checks++;
    if ({match, id_ok, ts_ok, fault} !== 4'b1110)
      $display("FAIL auto_verdict: got %b want 1110", {match, id_ok, ts_ok, fault});
    else n_pass++;
    n_checks++;
    if (acc_n !== 2 || acc_seq !== 1) $display("FAIL auto_addr_seq: got n=%0d seq=%0d want n=2 seq=1", acc_n, acc_seq);
    else n_pass++;
    m_id_val = EXP_ID; m_ts_val = EXP_TS;
    @(posedge clk); #1;
  endtask

  task automatic test_id_mismatch();
    int lat, an, as_; bit sd, sf, us, eb; int ed;
    transact(32'hA0130918, EXP_TS, 0, 0, 0, lat, sd, sf, an, as_, us, ed, eb);
    m_id_val = 32'hA0130918; m_ts_val = EXP_TS;
    n_checks++;
    if ({sd, id_ok, ts_ok, match} !== 4'b1010)
      $display("FAIL id_mismatch_flags: got %b want 1010", {sd, id_ok, ts_ok, match});
    else n_pass++;
    n_checks++;
    if (id_value !== 32'hA0130918) $display("FAIL id_mismatch_value: got %h want a0130918", id_value);
    else n_pass++;
  endtask

  task automatic test_stalls();
    int lat, an, as_; bit sd, sf, us, eb; int ed;
    transact(EXP_ID, EXP_TS, 3, 3, 0, lat, sd, sf, an, as_, us, ed, eb);
    n_checks++;
    if (!sd || lat !== 9) $display("FAIL stall_latency: got done=%0b lat=%0d want done=1 lat=9", sd, lat);
    else n_pass++;
    n_checks++;
    if (us !== 1'b0) $display("FAIL stall_stable: got unstable=%0b want 0", us); else n_pass++;
    n_checks++;
    if (match !== 1'b1 || ed !== 0) $display("FAIL stall_match: got match=%0b extra_done=%0d want 1/0", match, ed);
    else n_pass++;
    m_id_val = EXP_ID; m_ts_val = EXP_TS;
  endtask

  task automatic test_timeout();
    int lat, an, as_; bit sd, sf, us, eb; int ed;
    transact(EXP_ID, EXP_TS, 20, 0, 0, lat, sd, sf, an, as_, us, ed, eb);
    n_checks++;
    if (!sf || lat !== TMO + 1) $display("FAIL timeout_latency: got fault=%0b lat=%0d want 1/%0d", sf, lat, TMO + 1);
    else n_pass++;
    n_checks++;
    if ({sd, ed != 0, avm_read, match, id_ok, ts_ok, fault} !== 7'b0000001)
      $display("FAIL timeout_outputs: got %b want 0000001", {sd, ed != 0, avm_read, match, id_ok, ts_ok, fault});
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat, an, as_; bit sd, sf, us, eb; int ed;
    transact(EXP_ID, EXP_TS, 3, 3, 1, lat, sd, sf, an, as_, us, ed, eb);
    n_checks++;
    if (lat !== 9 || ed !== 0 || eb !== 1'b0)
      $display("FAIL busy_start_ignored: got lat=%0d extra_done=%0d busy=%0b want 9/0/0", lat, ed, eb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pos[$];
    id_word = EXP_ID; ts_word = EXP_TS; st_id = 0; st_ts = 0;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done) pos.push_back(c);
    end
    start = 1'b0;
    n_checks++;
    if (pos.size() !== 4) $display("FAIL b2b_count: got %0d want 4", pos.size());
    else n_pass++;
    for (int i = 0; i < pos.size() && i < 4; i++) begin
      n_checks++;
      if (pos[i] !== 3 * (i + 1)) $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, pos[i], 3 * (i + 1));
      else n_pass++;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (match !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_final: got match=%0b busy=%0b want 1/0", match, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, an, as_, ed, sid, sts, e_lat, e_an, e_as;
    bit sd, sf, us, eb, e_done, e_fault, e_idok, e_tsok, e_match;
    logic [31:0] idw, tsw;
    for (int it = 0; it < 24; it++) begin
      idw = ($urandom_range(0, 2) == 0) ? (EXP_ID ^ (32'h1 << $urandom_range(0, 31))) : EXP_ID;
      tsw = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      sid = $urandom_range(0, 5);
      sts = $urandom_range(0, 5);
      transact(idw, tsw, sid, sts, 0, lat, sd, sf, an, as_, us, ed, eb);
      model(idw, tsw, sid, sts, e_done, e_fault, e_lat, e_an, e_as, e_idok, e_tsok, e_match);
      n_checks++;
      if (sd !== e_done || sf !== e_fault || lat !== e_lat)
        $display("FAIL rnd%0d_event: got done=%0b fault=%0b lat=%0d want %0b/%0b/%0d", it, sd, sf, lat, e_done, e_fault, e_lat);
      else n_pass++;
      n_checks++;
      if ({id_ok, ts_ok, match, fault} !== {e_idok, e_tsok, e_match, e_fault})
        $display("FAIL rnd%0d_flags: got %b want %b", it, {id_ok, ts_ok, match, fault}, {e_idok, e_tsok, e_match, e_fault});
      else n_pass++;
      n_checks++;
      if (id_value !== m_id_val || ts_value !== m_ts_val)
        $display("FAIL rnd%0d_values: got %h/%h want %h/%h", it, id_value, ts_value, m_id_val, m_ts_val);
      else n_pass++;
      n_checks++;
      if (an !== e_an || as_ !== e_as || us !== 1'b0 || ed !== 0 || eb !== 1'b0)
        $display("FAIL rnd%0d_bus: got n=%0d seq=%0d unstable=%0b extra=%0d busy=%0b want %0d/%0d/0/0/0",
                 it, an, as_, us, ed, eb, e_an, e_as);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midcheck();
    int lat;
    wr_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wr_b = 1'b0;
    @(posedge clk); #1;
    wr_b = 1'b1;
    n_checks++;
    if (addr_b !== 1'b1 || read_b !== 1'b1 || id_value_b !== EXP_ID)
      $display("FAIL midreset_in_rdts: got addr=%0b read=%0b id=%h want 1/1/%h", addr_b, read_b, id_value_b, EXP_ID);
    else n_pass++;
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy_b, done_b, match_b, id_ok_b, ts_ok_b, fault_b, read_b, addr_b} !== 8'h00 ||
        id_value_b !== 32'h0 || ts_value_b !== 32'h0)
      $display("FAIL midreset_cleared: got %b %h %h want 00000000 0 0",
               {busy_b, done_b, match_b, id_ok_b, ts_ok_b, fault_b, read_b, addr_b}, id_value_b, ts_value_b);
    else n_pass++;
    reset_b = 1'b0;
    wr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (read_b !== 1'b0) $display("FAIL midreset_no_autostart: got read=%0b want 0", read_b);
    else n_pass++;
    start_b = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      if (done_b) lat = c;
    end
    n_checks++;
    if (lat !== 3 || match_b !== 1'b1) $display("FAIL midreset_recheck: got lat=%0d match=%0b want 3/1", lat, match_b);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; wr_b = 1'b0;
    id_word = EXP_ID; ts_word = EXP_TS; st_id = 0; st_ts = 0;
    m_id_val = '0; m_ts_val = '0;
    test_reset();
    reset_b = 1'b0;
    test_auto_start();
    test_id_mismatch();
    test_stalls();
    test_timeout();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_midcheck();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cq_viola_sysid_checker.md
# cq_viola_sysid_checker

Avalon-MM master that sequences read-back of the system ID peripheral: it reads the ID word (word address 0) and the timestamp word (word address 1), compares each with build-time expected values and publishes a latched match verdict. It sits between the sysid control slave and boot/supervisor logic, which uses `match` to gate startup and `fault` to flag a hung or mismatched fabric. It runs one check automatically after reset and repeats on request.

## Interface
Parameters:
- `EXPECT_ID`, 32'hA0130917: expected word at address 0.
- `EXPECT_TS`, 32'h52673D51: expected word at address 1.
- `TIMEOUT_CYCLES`, 255: maximum waitrequest-stalled cycles per read; 0 disables the timeout.
- `AUTO_START`, 1: 1 starts a check on the first cycle after reset is released.

Ports:
- `clock`  in  1  single clock domain; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a check; sampled only when not `busy`.
- `busy`  out  1  high while a check is in progress.
- `done`  out  1  one-cycle pulse when a check completes with both words read.
- `match`  out  1  latched: both words equal their expected values.
- `id_ok`, `ts_ok`  out  1 each  latched per-word compare results.
- `fault`  out  1  latched: last check aborted by timeout.
- `id_value`, `ts_value`  out  32 each  last captured words.
- `avm_address`  out  1  word address to the sysid slave.
- `avm_read`  out  1  Avalon read strobe.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data, valid in the cycle where `avm_read`=1 and `avm_waitrequest`=0.

## Operation
- States: IDLE, RD_ID, RD_TS, DONE, FAULT. All outputs are registered.
- IDLE/DONE/FAULT with `start`=1 (or the auto-start event) -> RD_ID. Entering RD_ID clears `match`, `id_ok`, `ts_ok`, `fault` and the timeout counter.
- RD_ID: `avm_read`=1, `avm_address`=0. On accept (waitrequest=0), capture `id_value` and set `id_ok` = (readdata==EXPECT_ID), then go to RD_TS.
- RD_TS: `avm_read`=1, `avm_address`=1. On accept, capture `ts_value` and set `ts_ok`, then go to DONE. On entry to DONE, `match` = `id_ok` & `ts_ok`(new) and `done` pulses.
- Reads are back-to-back: `avm_read` stays high across the RD_ID->RD_TS transition. Address and read are held stable while waitrequest=1.
- Timeout: the counter increments on each read-state cycle with waitrequest=1 and resets on accept. When it reaches TIMEOUT_CYCLES:
  - drop `avm_read`, go to FAULT, set `fault`=1, `match`=0;
  - the word not read keeps its ok flag at 0;
  - no `done` pulse.
  - This abort is intentional for a hung fabric only.
- Counter width is clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=0 the counter never fires.
- `start` while `busy` is ignored; it is not queued.
- `busy` = state is RD_ID or RD_TS.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `match`, `id_ok`, `ts_ok`, `fault`, `avm_read`, `avm_address` = 0;
  - `id_value`, `ts_value` = 0.
- Reset asserted mid-check: at the next edge the block is in IDLE with `avm_read`=0. Any in-flight read is abandoned.
- Start latency: `start` high at edge N -> `avm_read`=1 and `busy`=1 from edge N+1.
- AUTO_START: the first edge with `reset`=0 behaves like `start`, so reads begin on the following cycle.
- Zero-wait check: RD_ID 1 cycle, RD_TS 1 cycle, then `done`=1 for exactly 1 cycle. Start-to-done = 3 cycles.
- Each waitrequest cycle adds 1 cycle.
- Timeout: FAULT is entered on the edge after TIMEOUT_CYCLES consecutive stalled cycles in one read state.
- `start` coinciding with a `done` pulse: the DONE state accepts it, so the new check begins next cycle. `done` still pulses for the completed check.

## Test plan
- Auto-start, zero-wait slave returning 32'hA0130917 / 32'h52673D51 -> `done` pulses 3 cycles after reset release; `match`=`id_ok`=`ts_ok`=1; `avm_address` sequence 0,1.
- Slave returns ID 32'hA0130918 -> `id_ok`=0, `ts_ok`=1, `match`=0; `id_value`=32'hA0130918.
- Waitrequest held for 3 cycles on each read -> `done` at start+9 cycles; address and read are stable during stalls; `match`=1.
- Waitrequest stuck high with TIMEOUT_CYCLES=4 -> `fault`=1 after 4 stalled cycles in RD_ID; `avm_read`=0; no `done`; `match`=0.
- Reset asserted during RD_TS, then `start` pulsed with AUTO_START=0 -> all outputs 0 after reset; a fresh check completes with `match`=1.
- `start` held high continuously -> checks repeat back-to-back; `start` pulses while `busy`=1 have no effect.
